// File: rtl/pipe_seq_ctrl.sv
// pipe_seq_ctrl: 5-stage pipeline sequencer (stall, flush, redirect, trap entry).
// Optional PIPE_PERF_CNT_EN adds saturating stall/flush counters.
module pipe_seq_ctrl #(
    parameter int          MEM_TIMEOUT = 16,
    parameter logic [31:0] TRAP_VEC    = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        idexMemRead,
    input  logic [4:0]  idexRd,
    input  logic [4:0]  ifidRs1,
    input  logic [4:0]  ifidRs2,
    input  logic        brTaken,
    input  logic [31:0] brTarget,
    input  logic        memReq,
    input  logic        memAck,
    input  logic        excReq,
    output logic        pcWe,
    output logic        ifidWe,
    output logic        idexWe,
    output logic        exmemWe,
    output logic        mewbWe,
    output logic        ifidFlush,
    output logic        idexFlush,
    output logic        exmemFlush,
    output logic        pcSel,
    output logic [31:0] pcTarget,
    output logic        busErr,
    output logic        trapActive
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] stallCnt,
    output logic [31:0] flushCnt
`endif
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, TRAP1, TRAP2} state_t;
    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       load_use;
    assign load_use = idexMemRead && idexRd != 5'd0 && (idexRd == ifidRs1 || idexRd == ifidRs2);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        pcWe       = 1'b0;
        ifidWe     = 1'b0;
        idexWe     = 1'b0;
        exmemWe    = 1'b0;
        mewbWe     = 1'b0;
        ifidFlush  = 1'b0;
        idexFlush  = 1'b0;
        exmemFlush = 1'b0;
        pcSel      = 1'b0;
        pcTarget   = 32'd0;
        busErr     = 1'b0;
        trapActive = 1'b0;
        case (state_q)
            RUN: begin
                {pcWe, ifidWe, idexWe, exmemWe, mewbWe} = 5'b11111;
                if (excReq) begin
                    state_d = TRAP1;
                    pcWe    = 1'b0;
                    {ifidFlush, idexFlush, exmemFlush} = 3'b111;
                end else if (memReq && !memAck) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                    {pcWe, ifidWe, idexWe, exmemWe, mewbWe} = 5'b00000;
                end else if (load_use) begin
                    pcWe      = 1'b0;
                    ifidWe    = 1'b0;
                    idexFlush = 1'b1;
                end else if (brTaken) begin
                    pcSel     = 1'b1;
                    pcTarget  = brTarget;
                    ifidFlush = 1'b1;
                    idexFlush = 1'b1;
                end
            end
            MEM_WAIT: begin
                // excReq is deliberately not sampled while the access is outstanding
                if (memAck) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == 8'(MEM_TIMEOUT - 1)) begin
                    busErr     = 1'b1;
                    state_d    = TRAP1;
                    wait_cnt_d = 8'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            TRAP1: begin
                pcSel      = 1'b1;
                pcTarget   = TRAP_VEC;
                pcWe       = 1'b1;
                trapActive = 1'b1;
                {ifidFlush, idexFlush, exmemFlush} = 3'b111;
                state_d    = TRAP2;
            end
            TRAP2: begin
                pcWe       = 1'b1;
                ifidWe     = 1'b1;
                idexFlush  = 1'b1;
                exmemFlush = 1'b1;
                trapActive = 1'b1;
                state_d    = RUN;
            end
            default: state_d = RUN;
        endcase
        if (!rst) begin
            {pcWe, ifidWe, idexWe, exmemWe, mewbWe} = 5'b00000;
            {ifidFlush, idexFlush, exmemFlush}      = 3'b000;
            pcSel      = 1'b0;
            pcTarget   = 32'd0;
            busErr     = 1'b0;
            trapActive = 1'b0;
        end
    end
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (!pcWe && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
            if ((ifidFlush || idexFlush || exmemFlush) && flush_cnt_q != 32'hFFFF_FFFF)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end
    assign stallCnt = stall_cnt_q;
    assign flushCnt = flush_cnt_q;
`endif
endmodule
